alignment_capture_sequencer: RTL and testbench

- Sequences one capture run of the data-alignment block: alignment reset → arm → count N output beats → read back the alignment counter → report status.
- Drives the alignment block's 32-bit command word and watches its ready_to_read / counter_value pair.
- Passively monitors the 128-bit M00 stream handshake and gates downstream acceptance through stream_enable.
- Sits between the host register interface and the alignment datapath.

---
 rtl/alignment_capture_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_alignment_capture_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alignment_capture_sequencer.sv
// Capture-run sequencer for the data-alignment block: align reset, arm, count M00 beats, read back, report.
// Optional auto-rearm from DONE is enabled by defining ALIGN_CAPSEQ_REARM_EN.

// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start, command = NOP
// ALIGN_RST | command = RESET held for RST_CYCLES cycles
// ARM       | command = ARM(beat_count), waiting for ready_to_read
// CAPTURE   | stream_enable high, counting M00 handshakes up to beat_count
// READ      | command = READ, latching counter_value on ready_to_read
// DONE      | one-cycle done pulse
// ERROR     | ready_to_read never came, sets timeout_err
module alignment_capture_sequencer #(
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [CNT_W-1:0] beat_count,
  output logic [31:0]      command,
  input  logic [31:0]      counter_value,
  input  logic             ready_to_read,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  output logic             stream_enable,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             aborted,
  output logic [CNT_W-1:0] captured_beats,
  output logic [31:0]      last_counter
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ALIGN_RST = 3'd1,
    S_ARM       = 3'd2,
    S_CAPTURE   = 3'd3,
    S_READ      = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_RESET = 4'h1;
  localparam logic [3:0] OP_ARM   = 4'h2;
  localparam logic [3:0] OP_READ  = 4'h3;

  localparam int TMR_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] TMR_RST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_TO  = TMR_W'(TIMEOUT_CYCLES - 1);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             tmr_tc;
  logic [CNT_W-1:0] beat_lat;
  logic             start_acc;
  logic             abort_hit;
  logic             beat_hs;
  logic             last_beat;
  logic             rearm;
  logic [27:0]      arm_operand;
  logic [31:0]      cmd_nxt;

  assign tmr_tc    = (tmr == '0);
  assign start_acc = (state == S_IDLE) && start && !abort;
  assign abort_hit = (state != S_IDLE) && abort;
  assign beat_hs   = (state == S_CAPTURE) && mon_tvalid && mon_tready && !abort;
  assign last_beat = ((captured_beats + CNT_W'(1)) == beat_lat);
  assign arm_operand = 28'(beat_lat);

`ifdef ALIGN_CAPSEQ_REARM_EN
  assign rearm = continuous;
`else
  logic unused_continuous;
  assign unused_continuous = continuous;
  assign rearm = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_acc) state_nxt = S_ALIGN_RST;
        end
        S_ALIGN_RST: begin
          if (tmr_tc) state_nxt = S_ARM;
        end
        S_ARM: begin
          if (ready_to_read) state_nxt = (beat_lat == '0) ? S_READ : S_CAPTURE;
          else if (tmr_tc)   state_nxt = S_ERROR;
        end
        S_CAPTURE: begin
          if (beat_hs && last_beat) state_nxt = S_READ;
        end
        S_READ: begin
          if (ready_to_read) state_nxt = S_DONE;
          else if (tmr_tc)   state_nxt = S_ERROR;
        end
        S_DONE: begin
          state_nxt = rearm ? S_ALIGN_RST : S_IDLE;
        end
        S_ERROR: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered so they line up with the state they describe.
  always_comb begin
    cmd_nxt = {OP_NOP, 28'd0};
    case (state_nxt)
      S_ALIGN_RST: cmd_nxt = {OP_RESET, 28'd0};
      S_ARM:       cmd_nxt = {OP_ARM, arm_operand};
      S_READ:      cmd_nxt = {OP_READ, 28'd0};
      default:     cmd_nxt = {OP_NOP, 28'd0};
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      command       <= 32'd0;
      stream_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      command       <= cmd_nxt;
      stream_enable <= (state_nxt == S_CAPTURE);
      busy          <= (state_nxt != S_IDLE);
      done          <= (state_nxt == S_DONE);
    end
  end

  // Single down-counter reused for the reset hold and both ready_to_read timeouts.
  always_ff @(posedge aclk) begin
    if (reset) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        S_ALIGN_RST:    tmr <= TMR_RST;
        S_ARM, S_READ:  tmr <= TMR_TO;
        default:        tmr <= '0;
      endcase
    end else if (!tmr_tc) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      beat_lat       <= '0;
      captured_beats <= '0;
      last_counter   <= 32'd0;
      timeout_err    <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      if (start_acc) begin
        beat_lat    <= beat_count;
        timeout_err <= 1'b0;
        aborted     <= 1'b0;
      end
      if (abort_hit) begin
        aborted <= 1'b1;
      end
      if ((state_nxt == S_ERROR) && (state != S_ERROR)) begin
        timeout_err <= 1'b1;
      end
      if ((state_nxt == S_ALIGN_RST) && (state != S_ALIGN_RST)) begin
        captured_beats <= '0;
      end else if (beat_hs) begin
        captured_beats <= captured_beats + CNT_W'(1);
      end
      if ((state == S_READ) && (state_nxt == S_DONE)) begin
        last_counter <= counter_value;
      end
    end
  end

endmodule

// File: tb/tb_alignment_capture_sequencer.sv
// Directed bench for alignment_capture_sequencer: vector table of complete runs plus hand sequences
// for timeout, abort, rearm (ALIGN_CAPSEQ_REARM_EN) and mid-run reset.
module tb_alignment_capture_sequencer;

  logic        aclk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [31:0] beat_count;
  logic [31:0] command;
  logic [31:0] counter_value;
  logic        ready_to_read;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        stream_enable;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        aborted;
  logic [31:0] captured_beats;
  logic [31:0] last_counter;

  int n_checks = 0;
  int n_fail   = 0;

  alignment_capture_sequencer dut (
    .aclk           (aclk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .continuous     (continuous),
    .beat_count     (beat_count),
    .command        (command),
    .counter_value  (counter_value),
    .ready_to_read  (ready_to_read),
    .mon_tvalid     (mon_tvalid),
    .mon_tready     (mon_tready),
    .stream_enable  (stream_enable),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .aborted        (aborted),
    .captured_beats (captured_beats),
    .last_counter   (last_counter)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] bc;
    int          arm_dly;
    int          read_dly;
    bit          toggle;
    bit          early_rdy;
    bit          poke_start;
    logic [31:0] cv;
    logic [31:0] exp_cap;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start_run(input logic [31:0] bc);
    beat_count = bc;
    start = 1'b1;
    step();
    start = 1'b0;
    beat_count = 32'hFFFF_FFF0;
    chk("start_busy", busy, 1'b1);
    chk("start_clr_timeout", timeout_err, 1'b0);
    chk("start_clr_aborted", aborted, 1'b0);
    chk("start_clr_captured", captured_beats, 32'd0);
  endtask

  task automatic phase_align(input bit early_rdy);
    for (int i = 0; i < 8; i++) begin
      chk("rst_cmd", command, 32'h1000_0000);
      chk("rst_se", stream_enable, 1'b0);
      chk("rst_busy", busy, 1'b1);
      ready_to_read = early_rdy;
      step();
    end
    ready_to_read = 1'b0;
  endtask

  task automatic phase_arm(input logic [31:0] bc, input int dly);
    logic [31:0] arm_cmd;
    arm_cmd = {4'h2, bc[27:0]};
    chk("arm_cmd", command, arm_cmd);
    for (int d = 0; d < dly; d++) begin
      step();
      chk("arm_hold", command, arm_cmd);
    end
    ready_to_read = 1'b1;
    step();
    ready_to_read = 1'b0;
  endtask

  task automatic phase_capture(input logic [31:0] bc, input bit toggle, input bit poke_start);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    if (bc == 32'd0) begin
      chk("zero_se", stream_enable, 1'b0);
    end else begin
      chk("cap_se_first", stream_enable, 1'b1);
      chk("cap_cmd", command, 32'd0);
      while (got < int'(bc) && cyc < 200) begin
        mon_tvalid = 1'b1;
        mon_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
        start = poke_start && (cyc == 1);
        if (mon_tvalid && mon_tready) got++;
        step();
        cyc++;
        chk("cap_cnt", captured_beats, 64'(got));
        chk("cap_se", stream_enable, got < int'(bc));
      end
      start = 1'b0;
      chk("cap_budget", 64'(got), bc);
    end
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
  endtask

  task automatic phase_read(input int dly, input logic [31:0] cv, input logic [31:0] exp_cap,
                            input logic [31:0] exp_last);
    chk("read_cmd", command, 32'h3000_0000);
    chk("read_se", stream_enable, 1'b0);
    for (int d = 0; d < dly; d++) begin
      counter_value = ~cv;
      step();
      chk("read_hold", command, 32'h3000_0000);
    end
    counter_value = cv;
    ready_to_read = 1'b1;
    step();
    ready_to_read = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    counter_value = 32'h5555_5555;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("last_counter", last_counter, exp_last);
    chk("captured", captured_beats, exp_cap);
    chk("done_cmd", command, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    start_run(v.bc);
    phase_align(v.early_rdy);
    phase_arm(v.bc, v.arm_dly);
    phase_capture(v.bc, v.toggle, v.poke_start);
    phase_read(v.read_dly, v.cv, v.exp_cap, v.exp_last);
    step();
    chk("end_done", done, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_cmd", command, 32'd0);
    chk("end_last", last_counter, v.exp_last);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{bc: 32'd4, arm_dly: 3, read_dly: 0, toggle: 1'b0, early_rdy: 1'b0, poke_start: 1'b0,
                cv: 32'h0000_00A5, exp_cap: 32'd4, exp_last: 32'h0000_00A5};
    vecs[1] = '{bc: 32'd0, arm_dly: 0, read_dly: 2, toggle: 1'b0, early_rdy: 1'b0, poke_start: 1'b0,
                cv: 32'h1234_5678, exp_cap: 32'd0, exp_last: 32'h1234_5678};
    vecs[2] = '{bc: 32'd4, arm_dly: 0, read_dly: 1, toggle: 1'b1, early_rdy: 1'b0, poke_start: 1'b1,
                cv: 32'hDEAD_BEEF, exp_cap: 32'd4, exp_last: 32'hDEAD_BEEF};
    vecs[3] = '{bc: 32'd1, arm_dly: 5, read_dly: 0, toggle: 1'b0, early_rdy: 1'b1, poke_start: 1'b0,
                cv: 32'hFFFF_FFFF, exp_cap: 32'd1, exp_last: 32'hFFFF_FFFF};
    vecs[4] = '{bc: 32'd3, arm_dly: 1, read_dly: 3, toggle: 1'b1, early_rdy: 1'b0, poke_start: 1'b0,
                cv: 32'h0000_0000, exp_cap: 32'd3, exp_last: 32'h0000_0000};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    beat_count = 32'd0;
    counter_value = 32'd0;
    ready_to_read = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_command", command, 32'd0);
    chk("rst_stream_enable", stream_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_captured", captured_beats, 32'd0);
    chk("rst_last_counter", last_counter, 32'd0);

    // ARM without ready_to_read: 1024 cycles, then ERROR for one cycle.
    start_run(32'd2);
    phase_align(1'b0);
    chk("to_arm_cmd", command, 32'h2000_0002);
    n = 0;
    while (command == 32'h2000_0002 && n < 2000) begin
      step();
      n++;
    end
    chk("to_arm_cycles", 64'(n), 64'd1024);
    chk("to_err_cmd", command, 32'd0);
    chk("to_err_flag", timeout_err, 1'b1);
    chk("to_err_busy", busy, 1'b1);
    chk("to_err_done", done, 1'b0);
    step();
    chk("to_idle_busy", busy, 1'b0);
    chk("to_idle_done", done, 1'b0);
    chk("to_sticky", timeout_err, 1'b1);

    // Abort after 2 of 6 beats.
    start_run(32'd6);
    phase_align(1'b0);
    phase_arm(32'd6, 0);
    chk("ab_se", stream_enable, 1'b1);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    repeat (2) step();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    chk("ab_cnt_before", captured_beats, 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_flag", aborted, 1'b1);
    chk("ab_captured", captured_beats, 32'd2);
    chk("ab_se_off", stream_enable, 1'b0);
    chk("ab_cmd", command, 32'd0);
    chk("ab_done", done, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_start_idle_busy", busy, 1'b0);
    chk("ab_start_idle_flag", aborted, 1'b1);
    step();
    chk("ab_start_idle_cmd", command, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    // continuous=1: back-to-back runs only when the rearm feature is built in.
    continuous = 1'b1;
    start_run(32'd2);
    phase_align(1'b0);
    phase_arm(32'd2, 0);
    phase_capture(32'd2, 1'b0, 1'b0);
    phase_read(0, 32'h0000_0077, 32'd2, 32'h0000_0077);
    step();
`ifdef ALIGN_CAPSEQ_REARM_EN
    continuous = 1'b0;
    chk("rearm_busy", busy, 1'b1);
    chk("rearm_done_low", done, 1'b0);
    chk("rearm_captured_clr", captured_beats, 32'd0);
    phase_align(1'b0);
    phase_arm(32'd2, 1);
    phase_capture(32'd2, 1'b0, 1'b0);
    phase_read(0, 32'h0000_0088, 32'd2, 32'h0000_0088);
    step();
`endif
    continuous = 1'b0;
    chk("cont_end_busy", busy, 1'b0);
    chk("cont_end_done", done, 1'b0);
    chk("cont_end_cmd", command, 32'd0);

    // Reset in the middle of ALIGN_RST clears everything, including last_counter.
    start_run(32'd5);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd", command, 32'd0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_last", last_counter, 32'd0);
    chk("mid_rst_captured", captured_beats, 32'd0);
    step();
    chk("mid_rst_idle_cmd", command, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
